// File: rtl/spu_writeback.sv
// rtl/spu_writeback.sv - dual-write, six-read 128-bit register file with write-through bypass and retire counters
module spu_writeback #(
    parameter int NUM_REGS = 128,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         iwb_rtaddr_e,
    input  logic               iwb_wreg_e,
    input  logic [127:0]       iwb_rt_e,
    input  logic [2:0]         iwb_uid_e,
    input  logic [6:0]         iwb_rtaddr_o,
    input  logic               iwb_wreg_o,
    input  logic [127:0]       iwb_rt_o,
    input  logic [2:0]         iwb_uid_o,
    input  logic [6:0]         rd_addr_ra_e,
    input  logic [6:0]         rd_addr_rb_e,
    input  logic [6:0]         rd_addr_rc_e,
    input  logic [6:0]         rd_addr_ra_o,
    input  logic [6:0]         rd_addr_rb_o,
    input  logic [6:0]         rd_addr_rc_o,
    output logic [127:0]       rd_data_ra_e,
    output logic [127:0]       rd_data_rb_e,
    output logic [127:0]       rd_data_rc_e,
    output logic [127:0]       rd_data_ra_o,
    output logic [127:0]       rd_data_rb_o,
    output logic [127:0]       rd_data_rc_o,
    output logic               wb_valid_e,
    output logic [6:0]         wb_rtaddr_e,
    output logic               wb_valid_o,
    output logic [6:0]         wb_rtaddr_o,
    output logic               wb_collision,
    output logic [CNT_W-1:0]   retire_cnt_e,
    output logic [CNT_W-1:0]   retire_cnt_o,
    output logic [15:0]        collision_cnt
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [127:0]     regs_q [NUM_REGS];
    logic [127:0]     regs_d [NUM_REGS];
    logic             wb_valid_e_q, wb_valid_e_d;
    logic [6:0]       wb_rtaddr_e_q, wb_rtaddr_e_d;
    logic             wb_valid_o_q, wb_valid_o_d;
    logic [6:0]       wb_rtaddr_o_q, wb_rtaddr_o_d;
    logic             wb_collision_q, wb_collision_d;
    logic [CNT_W-1:0] retire_cnt_e_q, retire_cnt_e_d;
    logic [CNT_W-1:0] retire_cnt_o_q, retire_cnt_o_d;
    logic [15:0]      collision_cnt_q, collision_cnt_d;

    logic             wr_e_ok;
    logic             wr_o_ok;
    logic             collision;
    logic [6:0]       rd_addr_a [6];
    logic [127:0]     rd_data_a [6];

    // Unit ids travel with the result but have no effect on the register file.
    logic             uid_unused;
    assign uid_unused = ^{iwb_uid_e, iwb_uid_o};

    function automatic logic in_range(input logic [6:0] a);
        return ({25'd0, a} < 32'(NUM_REGS));
    endfunction

    function automatic logic [AW-1:0] idx(input logic [6:0] a);
        return a[AW-1:0];
    endfunction

    assign rd_addr_a[0] = rd_addr_ra_e;
    assign rd_addr_a[1] = rd_addr_rb_e;
    assign rd_addr_a[2] = rd_addr_rc_e;
    assign rd_addr_a[3] = rd_addr_ra_o;
    assign rd_addr_a[4] = rd_addr_rb_o;
    assign rd_addr_a[5] = rd_addr_rc_o;

    assign rd_data_ra_e = rd_data_a[0];
    assign rd_data_rb_e = rd_data_a[1];
    assign rd_data_rc_e = rd_data_a[2];
    assign rd_data_ra_o = rd_data_a[3];
    assign rd_data_rb_o = rd_data_a[4];
    assign rd_data_rc_o = rd_data_a[5];

    always_comb begin
        wr_e_ok   = iwb_wreg_e && in_range(iwb_rtaddr_e);
        wr_o_ok   = iwb_wreg_o && in_range(iwb_rtaddr_o);
        collision = iwb_wreg_e && iwb_wreg_o && (iwb_rtaddr_e == iwb_rtaddr_o);
    end

    // The odd pipe is younger, so it owns the entry when both pipes target it.
    always_comb begin
        regs_d = regs_q;
        if (wr_e_ok && !collision) begin
            regs_d[idx(iwb_rtaddr_e)] = iwb_rt_e;
        end
        if (wr_o_ok) begin
            regs_d[idx(iwb_rtaddr_o)] = iwb_rt_o;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            rd_data_a[i] = '0;
            if (rst) begin
                if (wr_o_ok && (rd_addr_a[i] == iwb_rtaddr_o)) begin
                    rd_data_a[i] = iwb_rt_o;
                end else if (wr_e_ok && (rd_addr_a[i] == iwb_rtaddr_e)) begin
                    rd_data_a[i] = iwb_rt_e;
                end else if (in_range(rd_addr_a[i])) begin
                    rd_data_a[i] = regs_q[idx(rd_addr_a[i])];
                end
            end
        end
    end

    always_comb begin
        wb_valid_e_d    = iwb_wreg_e;
        wb_rtaddr_e_d   = iwb_rtaddr_e;
        wb_valid_o_d    = iwb_wreg_o;
        wb_rtaddr_o_d   = iwb_rtaddr_o;
        wb_collision_d  = collision;
        retire_cnt_e_d  = retire_cnt_e_q + {{(CNT_W-1){1'b0}}, iwb_wreg_e};
        retire_cnt_o_d  = retire_cnt_o_q + {{(CNT_W-1){1'b0}}, iwb_wreg_o};
        collision_cnt_d = collision_cnt_q;
        if (collision && (collision_cnt_q != 16'hFFFF)) begin
            collision_cnt_d = collision_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_valid_e_q    <= 1'b0;
            wb_rtaddr_e_q   <= '0;
            wb_valid_o_q    <= 1'b0;
            wb_rtaddr_o_q   <= '0;
            wb_collision_q  <= 1'b0;
            retire_cnt_e_q  <= '0;
            retire_cnt_o_q  <= '0;
            collision_cnt_q <= '0;
        end else begin
            regs_q          <= regs_d;
            wb_valid_e_q    <= wb_valid_e_d;
            wb_rtaddr_e_q   <= wb_rtaddr_e_d;
            wb_valid_o_q    <= wb_valid_o_d;
            wb_rtaddr_o_q   <= wb_rtaddr_o_d;
            wb_collision_q  <= wb_collision_d;
            retire_cnt_e_q  <= retire_cnt_e_d;
            retire_cnt_o_q  <= retire_cnt_o_d;
            collision_cnt_q <= collision_cnt_d;
        end
    end

    assign wb_valid_e    = wb_valid_e_q;
    assign wb_rtaddr_e   = wb_rtaddr_e_q;
    assign wb_valid_o    = wb_valid_o_q;
    assign wb_rtaddr_o   = wb_rtaddr_o_q;
    assign wb_collision  = wb_collision_q;
    assign retire_cnt_e  = retire_cnt_e_q;
    assign retire_cnt_o  = retire_cnt_o_q;
    assign collision_cnt = collision_cnt_q;

endmodule

// File: tb/tb_spu_writeback.sv
// tb/tb_spu_writeback.sv - scoreboard bench for spu_writeback with directed vectors
module tb_spu_writeback;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic         rst;
    logic [6:0]   iwb_rtaddr_e, iwb_rtaddr_o;
    logic         iwb_wreg_e, iwb_wreg_o;
    logic [127:0] iwb_rt_e, iwb_rt_o;
    logic [2:0]   iwb_uid_e, iwb_uid_o;
    logic [6:0]   rd_addr [6];
    logic [127:0] rd_data [6];
    logic [127:0] rd2_data [6];

    logic         wb_valid_e, wb_valid_o, wb_collision;
    logic [6:0]   wb_rtaddr_e, wb_rtaddr_o;
    logic [31:0]  retire_cnt_e, retire_cnt_o;
    logic [15:0]  collision_cnt;

    logic         v2_e, v2_o, coll2;
    logic [6:0]   a2_e, a2_o;
    logic [3:0]   rc2_e, rc2_o;
    logic [15:0]  cc2;

    spu_writeback dut (
        .clk(clk), .rst(rst),
        .iwb_rtaddr_e(iwb_rtaddr_e), .iwb_wreg_e(iwb_wreg_e), .iwb_rt_e(iwb_rt_e), .iwb_uid_e(iwb_uid_e),
        .iwb_rtaddr_o(iwb_rtaddr_o), .iwb_wreg_o(iwb_wreg_o), .iwb_rt_o(iwb_rt_o), .iwb_uid_o(iwb_uid_o),
        .rd_addr_ra_e(rd_addr[0]), .rd_addr_rb_e(rd_addr[1]), .rd_addr_rc_e(rd_addr[2]),
        .rd_addr_ra_o(rd_addr[3]), .rd_addr_rb_o(rd_addr[4]), .rd_addr_rc_o(rd_addr[5]),
        .rd_data_ra_e(rd_data[0]), .rd_data_rb_e(rd_data[1]), .rd_data_rc_e(rd_data[2]),
        .rd_data_ra_o(rd_data[3]), .rd_data_rb_o(rd_data[4]), .rd_data_rc_o(rd_data[5]),
        .wb_valid_e(wb_valid_e), .wb_rtaddr_e(wb_rtaddr_e),
        .wb_valid_o(wb_valid_o), .wb_rtaddr_o(wb_rtaddr_o),
        .wb_collision(wb_collision),
        .retire_cnt_e(retire_cnt_e), .retire_cnt_o(retire_cnt_o),
        .collision_cnt(collision_cnt)
    );

    spu_writeback #(.NUM_REGS(16), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .iwb_rtaddr_e(iwb_rtaddr_e), .iwb_wreg_e(iwb_wreg_e), .iwb_rt_e(iwb_rt_e), .iwb_uid_e(iwb_uid_e),
        .iwb_rtaddr_o(iwb_rtaddr_o), .iwb_wreg_o(iwb_wreg_o), .iwb_rt_o(iwb_rt_o), .iwb_uid_o(iwb_uid_o),
        .rd_addr_ra_e(rd_addr[0]), .rd_addr_rb_e(rd_addr[1]), .rd_addr_rc_e(rd_addr[2]),
        .rd_addr_ra_o(rd_addr[3]), .rd_addr_rb_o(rd_addr[4]), .rd_addr_rc_o(rd_addr[5]),
        .rd_data_ra_e(rd2_data[0]), .rd_data_rb_e(rd2_data[1]), .rd_data_rc_e(rd2_data[2]),
        .rd_data_ra_o(rd2_data[3]), .rd_data_rb_o(rd2_data[4]), .rd_data_rc_o(rd2_data[5]),
        .wb_valid_e(v2_e), .wb_rtaddr_e(a2_e),
        .wb_valid_o(v2_o), .wb_rtaddr_o(a2_o),
        .wb_collision(coll2),
        .retire_cnt_e(rc2_e), .retire_cnt_o(rc2_o),
        .collision_cnt(cc2)
    );

    typedef struct packed {
        logic        ve;
        logic [6:0]  ae;
        logic        vo;
        logic [6:0]  ao;
        logic        coll;
        logic [31:0] re;
        logic [31:0] ro;
        logic [15:0] cc;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_re = '0;
    logic [31:0] m_ro = '0;
    logic [15:0] m_cc = '0;

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] A5N = {16{8'h5A}};
    localparam logic [127:0] DX  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DY  = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
    localparam logic [127:0] DZ  = 128'hFEDC_BA98_7654_3210_0F0F_F0F0_AAAA_5555;
    localparam logic [127:0] E7  = 128'h0000_0000_0000_0000_0000_0000_0000_0E07;
    localparam logic [127:0] O7  = 128'h0000_0000_0000_0000_0000_0000_0000_0D07;
    localparam logic [127:0] DW  = 128'h2020_2020_2020_2020_2020_2020_2020_2020;
    localparam logic [127:0] DN  = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic we, input logic [6:0] ae, input logic [127:0] de,
                         input logic wo, input logic [6:0] ao, input logic [127:0] dv);
        exp_t e;
        @(negedge clk);
        iwb_wreg_e   = we;
        iwb_rtaddr_e = ae;
        iwb_rt_e     = de;
        iwb_uid_e    = we ? 3'($urandom_range(7, 1)) : 3'd0;
        iwb_wreg_o   = wo;
        iwb_rtaddr_o = ao;
        iwb_rt_o     = dv;
        iwb_uid_o    = wo ? 3'($urandom_range(7, 1)) : 3'd0;
        m_re = m_re + {31'd0, we};
        m_ro = m_ro + {31'd0, wo};
        if (we && wo && (ae == ao) && (m_cc != 16'hFFFF)) m_cc = m_cc + 16'd1;
        e.ve   = we;
        e.ae   = ae;
        e.vo   = wo;
        e.ao   = ao;
        e.coll = we && wo && (ae == ao);
        e.re   = m_re;
        e.ro   = m_ro;
        e.cc   = m_cc;
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, '0, 1'b0, 7'd0, '0);
    endtask

    task automatic rdchk(input int p, input logic [6:0] a, input logic [127:0] e, input string name);
        rd_addr[p] = a;
        #1;
        chk(name, rd_data[p], e);
    endtask

    task automatic model_reset();
        m_re = '0;
        m_ro = '0;
        m_cc = '0;
        sb.delete();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wb_valid_e",    128'(wb_valid_e),    128'(e.ve));
            chk("wb_rtaddr_e",   128'(wb_rtaddr_e),   128'(e.ae));
            chk("wb_valid_o",    128'(wb_valid_o),    128'(e.vo));
            chk("wb_rtaddr_o",   128'(wb_rtaddr_o),   128'(e.ao));
            chk("wb_collision",  128'(wb_collision),  128'(e.coll));
            chk("retire_cnt_e",  128'(retire_cnt_e),  128'(e.re));
            chk("retire_cnt_o",  128'(retire_cnt_o),  128'(e.ro));
            chk("collision_cnt", 128'(collision_cnt), 128'(e.cc));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        iwb_wreg_e = 1'b0; iwb_rtaddr_e = '0; iwb_rt_e = '0; iwb_uid_e = '0;
        iwb_wreg_o = 1'b0; iwb_rtaddr_o = '0; iwb_rt_o = '0; iwb_uid_o = '0;
        for (int i = 0; i < 6; i++) rd_addr[i] = 7'(i);
        repeat (3) @(negedge clk);

        // Reset state, including bypass suppression while in reset.
        #1;
        chk("rst_valid_e", 128'(wb_valid_e), '0);
        chk("rst_valid_o", 128'(wb_valid_o), '0);
        chk("rst_retire_e", 128'(retire_cnt_e), '0);
        chk("rst_coll_cnt", 128'(collision_cnt), '0);
        iwb_wreg_o = 1'b1; iwb_rtaddr_o = 7'd7; iwb_rt_o = DZ;
        rdchk(4, 7'd7, '0, "rst_bypass_suppressed");
        iwb_wreg_o = 1'b0; iwb_rtaddr_o = '0; iwb_rt_o = '0;
        @(negedge clk);
        #2 rst = 1'b1;

        // Even-only write.
        drive(1'b1, 7'd5, A5, 1'b0, 7'd0, '0);
        idle();
        rdchk(0, 7'd5, A5, "even_write_rd5");

        // Dual write to distinct addresses, read through all six ports.
        drive(1'b1, 7'd3, DX, 1'b1, 7'd4, DY);
        idle();
        rdchk(0, 7'd3, DX, "dual_ra_e");
        rdchk(1, 7'd4, DY, "dual_rb_e");
        rdchk(2, 7'd3, DX, "dual_rc_e");
        rdchk(3, 7'd4, DY, "dual_ra_o");
        rdchk(4, 7'd3, DX, "dual_rb_o");
        rdchk(5, 7'd4, DY, "dual_rc_o");

        // Same-address collision: odd data survives.
        drive(1'b1, 7'd9, 128'd1, 1'b1, 7'd9, 128'd2);
        idle();
        rdchk(1, 7'd9, 128'd2, "collision_rd9");
        rdchk(4, 7'd7, '0, "reg7_initial");

        // Write-through bypass and its priority.
        drive(1'b0, 7'd0, '0, 1'b1, 7'd7, DZ);
        rdchk(4, 7'd7, DZ, "bypass_odd");
        drive(1'b1, 7'd7, E7, 1'b1, 7'd7, O7);
        rdchk(4, 7'd7, O7, "bypass_both_rb_o");
        rdchk(0, 7'd7, O7, "bypass_both_ra_e");
        drive(1'b1, 7'd5, A5N, 1'b0, 7'd0, '0);
        rdchk(2, 7'd5, A5N, "bypass_even");
        idle();
        rdchk(3, 7'd7, O7, "array_reg7");
        rdchk(5, 7'd5, A5N, "array_reg5");

        // Address beyond a 16-entry instance is ignored and reads zero.
        drive(1'b1, 7'd20, DW, 1'b0, 7'd0, '0);
        rdchk(0, 7'd20, DW, "big_bypass20");
        chk("small_bypass20", rd2_data[0], '0);
        idle();
        rdchk(1, 7'd20, DW, "big_reg20");
        chk("small_reg20", rd2_data[1], '0);
        rd_addr[2] = 7'd5;
        #1 chk("small_reg5", rd2_data[2], A5N);

        // Fill regs 0-3, then assert reset mid-cycle during a write.
        drive(1'b1, 7'd0, DX, 1'b1, 7'd1, DY);
        drive(1'b1, 7'd2, DZ, 1'b1, 7'd3, A5);
        @(posedge clk);
        #3;
        for (int i = 0; i < 4; i++) rd_addr[i] = 7'(i);
        rd_addr[4] = 7'd2;
        #1;
        chk("fill_reg0", rd_data[0], DX);
        chk("fill_reg1", rd_data[1], DY);
        chk("fill_reg2", rd_data[2], DZ);
        chk("fill_reg3", rd_data[3], A5);
        iwb_wreg_e = 1'b1; iwb_rtaddr_e = 7'd2; iwb_rt_e = DN;
        iwb_wreg_o = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_valid_e", 128'(wb_valid_e), '0);
        chk("rst_mid_valid_o", 128'(wb_valid_o), '0);
        chk("rst_mid_rtaddr_e", 128'(wb_rtaddr_e), '0);
        chk("rst_mid_rtaddr_o", 128'(wb_rtaddr_o), '0);
        chk("rst_mid_retire_e", 128'(retire_cnt_e), '0);
        chk("rst_mid_retire_o", 128'(retire_cnt_o), '0);
        chk("rst_mid_coll_cnt", 128'(collision_cnt), '0);
        for (int i = 0; i < 5; i++) chk($sformatf("rst_mid_rd%0d", i), rd_data[i], '0);
        @(posedge clk);
        drive(1'b1, 7'd1, DN, 1'b0, 7'd0, '0);
        #2 rst = 1'b1;
        idle();
        rdchk(0, 7'd1, DN, "post_rst_reg1");
        rdchk(1, 7'd2, '0, "post_rst_reg2");
        rdchk(2, 7'd0, '0, "post_rst_reg0");

        // Collision counter saturation.
        @(negedge clk);
        force dut.collision_cnt_q = 16'hFFFE;
        #1 release dut.collision_cnt_q;
        m_cc = 16'hFFFE;
        #1 chk("coll_cnt_forced", 128'(collision_cnt), 128'(16'hFFFE));
        for (int i = 0; i < 3; i++) drive(1'b1, 7'd9, 128'(i), 1'b1, 7'd9, 128'(i + 8));
        idle();
        #2 chk("coll_cnt_sat", 128'(collision_cnt), 128'(16'hFFFF));

        // Retire counter wrap on a 4-bit instance.
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 7'(i), 128'(i + 1), 1'b0, 7'd0, '0);
            if (i == 0) #2 rst = 1'b1;
        end
        idle();
        @(posedge clk);
        #3;
        chk("wrap_retire_e", 128'(rc2_e), 128'(4'd1));
        chk("wrap_retire_o", 128'(rc2_o), 128'(4'd0));
        chk("nowrap_retire_e", 128'(retire_cnt_e), 128'(32'd17));
        chk("sb_drained", 128'(sb.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spu_writeback.md
SPU_WRITEBACK -- requirements
Module: spu_writeback

Interface
- Parameters: name, default, meaning.
- Ports: name, direction, width, meaning.

REQ-001 The block SHALL have parameter NUM_REGS, default 128, giving the number of 128-bit registers.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the retire counters.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have ports iwb_rtaddr_e, iwb_wreg_e, iwb_rt_e and iwb_uid_e, inputs of width 7, 1, 128 and 3, carrying the even-pipe result from FF7.
REQ-006 The block SHALL have ports iwb_rtaddr_o, iwb_wreg_o, iwb_rt_o and iwb_uid_o, inputs of width 7, 1, 128 and 3, carrying the odd-pipe result from FF7.
REQ-007 The block SHALL have six read ports rd_addr_N, input, 7, where N is in {ra_e, rb_e, rc_e, ra_o, rb_o, rc_o}.
REQ-008 Each read port SHALL have a matching rd_data_N, output, 128.
REQ-009 The block SHALL have port wb_valid_e, output, 1, and port wb_rtaddr_e, output, 7, giving the registered even-pipe commit report.
REQ-010 The block SHALL have port wb_valid_o, output, 1, and port wb_rtaddr_o, output, 7, giving the registered odd-pipe commit report.
REQ-011 The block SHALL have port wb_collision, output, 1, a one-cycle pulse flagging a same-address dual write.
REQ-012 The block SHALL have ports retire_cnt_e and retire_cnt_o, output, CNT_W, counting committed writes per pipe.
REQ-013 The block SHALL have port collision_cnt, output, 16, a saturating count of collisions.

Function
REQ-014 Storage SHALL be a NUM_REGS x 128-bit register array with two write ports (even, odd) and six read ports.
REQ-015 When iwb_wreg_e=1, the block SHALL write iwb_rt_e to entry iwb_rtaddr_e at the rising edge; iwb_wreg_o and the odd fields SHALL behave the same way.
REQ-016 Write latency SHALL be one cycle: data presented in cycle T is readable from the array in cycle T+1.
REQ-017 Collision: when both wreg are 1 and the addresses are equal, only the odd-pipe data SHALL be written.
REQ-018 On such a collision, wb_collision SHALL be 1 in the following cycle only.
REQ-019 On such a collision, collision_cnt SHALL increment by 1 and saturate at 16'hFFFF.
REQ-020 Reads SHALL be combinational from the array.
REQ-021 Write-through bypass: when rd_addr_N matches a write with wreg=1 in the same cycle, rd_data_N SHALL return the incoming write data.
REQ-022 Bypass priority SHALL be the odd write, then the even write, then the array content.
REQ-023 wb_valid_e and wb_rtaddr_e SHALL register iwb_wreg_e and iwb_rtaddr_e with one-cycle latency.
REQ-024 wb_valid_o and wb_rtaddr_o SHALL register iwb_wreg_o and iwb_rtaddr_o with one-cycle latency.
REQ-025 On a collision, wb_valid_e SHALL still report 1, so the scoreboard clears both entries.
REQ-026 retire_cnt_e SHALL increment by 1 for each cycle with iwb_wreg_e=1, including collisions.
REQ-027 retire_cnt_o SHALL increment by 1 for each cycle with iwb_wreg_o=1, including collisions.
REQ-028 Both retire counters SHALL wrap modulo 2^CNT_W.
REQ-029 iwb_uid_e and iwb_uid_o SHALL carry no functional effect beyond being accepted; uid 0 with wreg=0 is a bubble.
REQ-030 Addresses at or above NUM_REGS SHALL be ignored for writes and SHALL read as zero.

Reset
REQ-031 While rst=0, asynchronously, all register entries SHALL be cleared to 0.
REQ-032 While rst=0, asynchronously, wb_valid_e, wb_valid_o, wb_rtaddr_e, wb_rtaddr_o, wb_collision, retire_cnt_e, retire_cnt_o and collision_cnt SHALL be 0.
REQ-033 While rst=0, rd_data_N SHALL read 0, and bypass SHALL be suppressed.
REQ-034 Reset asserted mid-write SHALL discard that write.
REQ-035 The first write SHALL take effect on the first rising edge with rst=1.

Verification
REQ-036 The bench SHALL cover an even-only write: write e addr 5 = 128'hA5..A5, then read ra_e=5 next cycle -> A5..A5, wb_valid_e=1, wb_rtaddr_e=5, retire_cnt_e=1.
REQ-037 The bench SHALL cover a dual write to different addresses: e addr 3 = X, o addr 4 = Y -> next cycle reg3=X, reg4=Y, wb_collision=0, both retire counters +1.
REQ-038 The bench SHALL cover a collision: both write addr 9, e=1, o=2 -> reg9=2, wb_collision pulses 1 for one cycle, collision_cnt=1, wb_valid_e=wb_valid_o=1.
REQ-039 The bench SHALL cover bypass: reg7=0, write o addr 7 = Z while rd_addr_rb_o=7 in the same cycle -> rd_data_rb_o=Z combinationally; with both pipes writing addr 7, the odd data wins.
REQ-040 The bench SHALL cover reset: fill regs 0-3, assert rst=0 between clock edges -> all outputs and reg reads become 0 immediately; after release, the next write lands normally.
REQ-041 The bench SHALL cover saturation and wrap: force collision_cnt to 16'hFFFE and apply 3 collisions -> it holds at FFFF; with CNT_W=4 and 17 even writes, retire_cnt_e=1.
